cfg_axil_arbiter: RTL
=====================

// Module: cfg_axil_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares the single config AXI-Lite master (15-bit addr) between
//  two requesters: port 0 = Wishbone bridge side, port 1 = FPGA Axis-Axilite side. Latches one
//  request, runs one full AXI-Lite transaction (AW+W+B or AR+R), returns a one-cycle response.
//  Sits between the requester front-ends and the target-select decode of the config controller.
// PARAMETERS
//  pADDR_WIDTH  15  AXI-Lite address width driven to targets
//  pDATA_WIDTH  32  data width
//  pTO_CYCLES   255 watchdog limit in cycles (used only with CFG_ARB_TIMEOUT_EN)
// PORTS
//  axi_clk        in   1   clock
//  axi_reset_n    in   1   async active-low reset
//  req{0,1}_valid in   1   request pending; held until req{n}_ready
//  req{0,1}_we    in   1   1=write, 0=read
//  req{0,1}_addr  in   15  byte address
//  req{0,1}_wdata in   32  write data
//  req{0,1}_wstrb in   4   write byte strobes
//  req{0,1}_ready out  1   request accepted (1-cycle pulse)
//  rsp{0,1}_valid out  1   response (1-cycle pulse, no backpressure)
//  rsp{0,1}_rdata out  32  read data, 0 for writes
//  rsp{0,1}_err   out  1   SLVERR/DECERR or timeout
//  axi_awvalid/axi_awready/axi_awaddr[14:0], axi_wvalid/axi_wready/axi_wdata[31:0]/axi_wstrb[3:0]
//  axi_bvalid/axi_bready/axi_bresp[1:0], axi_arvalid/axi_arready/axi_araddr[14:0]
//  axi_rvalid/axi_rready/axi_rdata[31:0]/axi_rresp[1:0]   standard AXI-Lite master, out/in as usual
// BEHAVIOUR
//  Reset: FSM=IDLE, last_grant=1, all valids/readys/rsp outputs 0, addr/data/strb outputs 0.
//  FSM IDLE->ADDR->RESP->DONE->IDLE.
//  IDLE: if any req_valid, grant: only one valid -> that one; both -> the one != last_grant.
//   req{g}_ready pulses this cycle; addr/we/wdata/wstrb latched; last_grant<=g; ->ADDR.
//  ADDR: write: awvalid and wvalid rise in cycle after accept, each dropped independently on its
//   own ready handshake; ->RESP when both done (same or different cycles). Read: arvalid until
//   arready; ->RESP. Address/data outputs stable while valid; 0 when valid low.
//  RESP: bready (write) or rready (read) held 1; on bvalid/rvalid capture rdata (write: 0) and
//   err=resp[1]; ->DONE.
//  DONE: rsp{g}_valid=1 for exactly one cycle with rdata/err; ->IDLE. No grant in DONE, so min
//   gap between accepts is 4 cycles; best-case accept->rsp latency 3 cycles (ready same cycle).
//  Requests arriving mid-transaction wait; req_valid dropping before ready is a protocol error,
//   not checked. Reset mid-transaction aborts immediately to reset state; no response issued.
//  Only granted port sees rsp_valid; the other port's rsp outputs stay 0.
// CONFIGURATION
//  CFG_ARB_TIMEOUT_EN defined: 8-bit cycle counter cleared on ADDR entry, counts in ADDR and RESP;
//   reaching pTO_CYCLES deasserts all AXI valids/readys, ->DONE with err=1, rdata=32'hDEAD_BEEF.
//  Undefined: no counter; a non-responding target hangs the arbiter until reset.
// TESTING
//  1 Reset: after reset, all outputs 0; req0/req1 both valid in same cycle -> req0_ready first.
//  2 req1 write addr 15'h4010 data 32'h0000_0005 strb 4'hF, targets ready 1 cycle later ->
//    awaddr/wdata seen, bresp OKAY, rsp1_valid 1 cycle, err=0, rdata=0.
//  3 Both valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
//  4 Read 15'h2000, awready/wready skew (write) and arready 3 cycles late, rdata 32'h1234_5678 ->
//    rsp rdata=32'h1234_5678; write with wready 2 cycles after awready completes once.
//  5 rresp=2'b10 -> rsp_err=1; with CFG_ARB_TIMEOUT_EN and no arready -> err=1, rdata=32'hDEAD_BEEF
//    exactly pTO_CYCLES after entering ADDR; without macro arvalid stays high indefinitely.
//  6 Assert axi_reset_n low during RESP -> outputs 0 next edge, no rsp pulse, next request serviced.

Source files
------------

// File: rtl/cfg_axil_arbiter.sv
// cfg_axil_arbiter
//   Round-robin arbiter and sequencer that shares one config AXI-Lite master between two
//   requesters (port 0 = Wishbone bridge side, port 1 = FPGA Axis-Axilite side). It latches
//   one request, runs one complete AXI-Lite transaction (AW+W+B or AR+R) and returns a
//   single-cycle response to the requester that was granted.
//
// Ports
//   axi_clk, axi_reset_n               clock, asynchronous active-low reset
//   req{0,1}_valid/_we/_addr/_wdata/_wstrb   request in, held until req{n}_ready
//   req{0,1}_ready                      one-cycle accept pulse
//   rsp{0,1}_valid/_rdata/_err          one-cycle response (rdata 0 for writes)
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r*     AXI-Lite master towards the target decode
//
// Optional feature
//   CFG_ARB_TIMEOUT_EN : watchdog that abandons a transaction after pTO_CYCLES cycles in
//   ADDR/RESP and responds with err=1, rdata=32'hDEAD_BEEF. Without it a silent target
//   stalls the arbiter until reset.

module cfg_axil_arbiter #(
    parameter int pADDR_WIDTH = 15,
    parameter int pDATA_WIDTH = 32,
    parameter int pTO_CYCLES  = 255
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     req0_valid,
    input  logic                     req0_we,
    input  logic [pADDR_WIDTH-1:0]   req0_addr,
    input  logic [pDATA_WIDTH-1:0]   req0_wdata,
    input  logic [3:0]               req0_wstrb,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic                     req1_we,
    input  logic [pADDR_WIDTH-1:0]   req1_addr,
    input  logic [pDATA_WIDTH-1:0]   req1_wdata,
    input  logic [3:0]               req1_wstrb,
    output logic                     req1_ready,
    output logic                     rsp0_valid,
    output logic [pDATA_WIDTH-1:0]   rsp0_rdata,
    output logic                     rsp0_err,
    output logic                     rsp1_valid,
    output logic [pDATA_WIDTH-1:0]   rsp1_rdata,
    output logic                     rsp1_err,
    output logic                     axi_awvalid,
    input  logic                     axi_awready,
    output logic [pADDR_WIDTH-1:0]   axi_awaddr,
    output logic                     axi_wvalid,
    input  logic                     axi_wready,
    output logic [pDATA_WIDTH-1:0]   axi_wdata,
    output logic [3:0]               axi_wstrb,
    input  logic                     axi_bvalid,
    output logic                     axi_bready,
    input  logic [1:0]               axi_bresp,
    output logic                     axi_arvalid,
    input  logic                     axi_arready,
    output logic [pADDR_WIDTH-1:0]   axi_araddr,
    input  logic                     axi_rvalid,
    output logic                     axi_rready,
    input  logic [pDATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]               axi_rresp
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     lastGrant_q, lastGrant_d;
    logic                     we_q, we_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [pDATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic                     awDone_q, awDone_d;
    logic                     wDone_q, wDone_d;
    logic [pDATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     pick;
    logic                     timeout;

    // Only SLVERR/DECERR (resp[1]) matter, so bit 0 of each response is ignored.
    logic unusedBits;
    assign unusedBits = ^{axi_bresp[0], axi_rresp[0], 32'(pTO_CYCLES)};

    // With both requesters waiting, the one that was not served last wins.
    assign pick = (req0_valid && req1_valid) ? ~lastGrant_q : req1_valid;

`ifdef CFG_ARB_TIMEOUT_EN
    logic [7:0] toCnt_q, toCnt_d;
    // Fires in the last allowed cycle so DONE starts exactly pTO_CYCLES after ADDR entry.
    assign timeout = ((state_q == ADDR) || (state_q == RESP)) &&
                     (toCnt_q == 8'(pTO_CYCLES - 1));

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) toCnt_q <= '0;
        else              toCnt_q <= toCnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awDone_q    <= 1'b0;
            wDone_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awDone_q    <= awDone_d;
            wDone_q     <= wDone_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awDone_d    = awDone_q;
        wDone_d     = wDone_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef CFG_ARB_TIMEOUT_EN
        toCnt_d     = toCnt_q;
`endif
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp0_rdata  = '0;
        rsp0_err    = 1'b0;
        rsp1_valid  = 1'b0;
        rsp1_rdata  = '0;
        rsp1_err    = 1'b0;
        axi_awvalid = 1'b0;
        axi_awaddr  = '0;
        axi_wvalid  = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0;
        axi_araddr  = '0;
        axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready  = ~pick;
                    req1_ready  = pick;
                    grant_d     = pick;
                    lastGrant_d = pick;
                    we_d        = pick ? req1_we    : req0_we;
                    addr_d      = pick ? req1_addr  : req0_addr;
                    wdata_d     = pick ? req1_wdata : req0_wdata;
                    wstrb_d     = pick ? req1_wstrb : req0_wstrb;
                    awDone_d    = 1'b0;
                    wDone_d     = 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
                    toCnt_d     = '0;
`endif
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (we_q) begin
                    // AW and W complete independently; the done flags remember which
                    // channel has already handshaken so its valid stays low.
                    if (!awDone_q && !timeout) begin
                        axi_awvalid = 1'b1;
                        axi_awaddr  = addr_q;
                    end
                    if (!wDone_q && !timeout) begin
                        axi_wvalid = 1'b1;
                        axi_wdata  = wdata_q;
                        axi_wstrb  = wstrb_q;
                    end
                    awDone_d = awDone_q | (axi_awvalid & axi_awready);
                    wDone_d  = wDone_q  | (axi_wvalid  & axi_wready);
                    if (awDone_d && wDone_d) state_d = RESP;
                end else begin
                    if (!timeout) begin
                        axi_arvalid = 1'b1;
                        axi_araddr  = addr_q;
                    end
                    if (axi_arvalid && axi_arready) state_d = RESP;
                end
            end
            RESP: begin
                if (we_q) begin
                    axi_bready = ~timeout;
                    if (axi_bvalid && axi_bready) begin
                        rdata_d = '0;
                        err_d   = axi_bresp[1];
                        state_d = DONE;
                    end
                end else begin
                    axi_rready = ~timeout;
                    if (axi_rvalid && axi_rready) begin
                        rdata_d = axi_rdata;
                        err_d   = axi_rresp[1];
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (grant_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = rdata_q;
                    rsp1_err   = err_q;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = rdata_q;
                    rsp0_err   = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef CFG_ARB_TIMEOUT_EN
        if ((state_q == ADDR) || (state_q == RESP)) toCnt_d = toCnt_q + 8'd1;
        if (timeout) begin
            rdata_d = pDATA_WIDTH'(32'hDEAD_BEEF);
            err_d   = 1'b1;
            state_d = DONE;
        end
`endif
    end

endmodule
